// File: rtl/button_run_ctrl.sv
// Button front end for the single-cycle CPU: sync, debounce, rise pulses,
// HALT/RUN/STEP run control, soft-reset pulse and enabled-cycle counter.
module button_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic        clkX4,
    input  logic        rst,
    input  logic        btnC,
    input  logic        btnU,
    input  logic        btnD,
    output logic [2:0]  btnLevel,
    output logic [2:0]  btnRise,
    output logic [1:0]  runState,
    output logic        cpuEnable,
    output logic        softReset,
    output logic [15:0] enableCount
);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } run_state_t;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [2:0]           sync1;
    logic [2:0]           sync2;
    logic [2:0]           level;
    logic [2:0]           rise;
    logic [CNT_WIDTH-1:0] cnt [3];

    run_state_t state;
    run_state_t state_next;
    logic       soft_next;
    logic       soft_q;
    logic [15:0] count_q;

    // A level is accepted only after it differs for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clkX4) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            rise  <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= {btnD, btnU, btnC};
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                rise[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    level[i] <= sync2[i];
                    rise[i]  <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Up has priority over centre, centre over down.
    always_comb begin
        state_next = state;
        soft_next  = 1'b0;
        case (state)
            HALT: begin
                if (rise[1]) begin
                    soft_next = 1'b1;
                end else if (rise[0]) begin
                    state_next = RUN;
                end else if (rise[2]) begin
                    state_next = STEP;
                end
            end
            RUN: begin
                if (rise[1]) begin
                    soft_next  = 1'b1;
                    state_next = HALT;
                end else if (rise[0]) begin
                    state_next = HALT;
                end
            end
            STEP:    state_next = HALT;
            default: state_next = HALT;
        endcase
    end

    always_ff @(posedge clkX4) begin
        if (!rst) begin
            state   <= HALT;
            soft_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state  <= state_next;
            soft_q <= soft_next;
            if (soft_next) begin
                count_q <= '0;
            end else if (cpuEnable) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign cpuEnable   = (state == RUN) || (state == STEP);
    assign runState    = state;
    assign btnLevel    = level;
    assign btnRise     = rise;
    assign softReset   = soft_q;
    assign enableCount = count_q;

endmodule
